// File: rtl/eth_pkg.sv
// Shared Ethernet MAC definitions: framing constants, CRC32 step and RX state encoding.
package eth_pkg;

  localparam logic [7:0]  ETH_PRE       = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam int          ETH_MIN_FRAME = 64;
  localparam int          ETH_MAX_FRAME = 1518;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_PREAMBLE,
    RX_DATA,
    RX_EOF,
    RX_DROP
  } rx_state_t;

  // Reflected CRC32, one byte, LSB first; no final inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int unsigned i = 0; i < 8; i++) begin
      c = (c[0] ^ data[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/rx_mac.sv
// Receive MAC: preamble/SFD detect, 5-byte delay line to strip FCS, CRC32 and length check,
// byte-wide AXI-Stream output with the frame verdict on tuser of the final beat.
module rx_mac
  import eth_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MIN_FRAME  = ETH_MIN_FRAME,
  parameter int MAX_FRAME  = ETH_MAX_FRAME
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] rgmii_mac_rx_data,
  input  logic                  rgmii_mac_rx_dv,
  input  logic                  rgmii_mac_rx_er,
  input  logic                  rgmii_mac_rx_rdy,
  input  logic                  mii_select,
  output logic [DATA_WIDTH-1:0] m_rx_axis_tdata,
  output logic                  m_rx_axis_tvalid,
  output logic                  m_rx_axis_tlast,
  output logic                  m_rx_axis_tuser,
  output logic                  stat_crc_err
);

  rx_state_t             state;
  logic                  dv_q;
  logic                  phase;
  logic [3:0]            nib_lo;
  logic [DATA_WIDTH-1:0] dl [5];
  logic [2:0]            dl_cnt;
  logic [2:0]            pre_cnt;
  logic [31:0]           crc;
  logic [13:0]           count;
  logic                  er_seen;

  logic                  byte_stb;
  logic [DATA_WIDTH-1:0] rx_byte;
  logic                  crc_bad;
  logic                  bad_len;

  always_comb begin
    byte_stb = rgmii_mac_rx_rdy && rgmii_mac_rx_dv && (!mii_select || (dv_q && phase));
    rx_byte  = mii_select ? {rgmii_mac_rx_data[3:0], nib_lo} : rgmii_mac_rx_data;
    crc_bad  = (crc != CRC_RESIDUE);
    bad_len  = (count < 14'(MIN_FRAME)) || (count > 14'(MAX_FRAME));
  end

  // Nibble assembler: a dv rise (or dv low) forces the next nibble to be the low half.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dv_q   <= 1'b0;
      phase  <= 1'b0;
      nib_lo <= '0;
    end else if (rgmii_mac_rx_rdy) begin
      dv_q <= rgmii_mac_rx_dv;
      if (!rgmii_mac_rx_dv) begin
        phase <= 1'b0;
      end else if (!dv_q || !phase) begin
        nib_lo <= rgmii_mac_rx_data[3:0];
        phase  <= 1'b1;
      end else begin
        phase <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= RX_IDLE;
      pre_cnt          <= '0;
      dl_cnt           <= '0;
      crc              <= '1;
      count            <= '0;
      er_seen          <= 1'b0;
      m_rx_axis_tdata  <= '0;
      m_rx_axis_tvalid <= 1'b0;
      m_rx_axis_tlast  <= 1'b0;
      m_rx_axis_tuser  <= 1'b0;
      stat_crc_err     <= 1'b0;
      for (int unsigned i = 0; i < 5; i++) dl[i] <= '0;
    end else begin
      m_rx_axis_tvalid <= 1'b0;
      m_rx_axis_tlast  <= 1'b0;
      m_rx_axis_tuser  <= 1'b0;
      stat_crc_err     <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rgmii_mac_rx_rdy && rgmii_mac_rx_dv) begin
            state   <= RX_PREAMBLE;
            pre_cnt <= '0;
          end
        end
        RX_PREAMBLE: begin
          if (rgmii_mac_rx_rdy && !rgmii_mac_rx_dv) begin
            state <= RX_IDLE;
          end else if (byte_stb) begin
            if (rx_byte == ETH_SFD)
              state <= RX_DATA;
            else if (rx_byte == ETH_PRE && pre_cnt != 3'd7)
              pre_cnt <= pre_cnt + 3'd1;
            else
              state <= RX_DROP;
          end
        end
        RX_DATA: begin
          if (rgmii_mac_rx_rdy && !rgmii_mac_rx_dv) begin
            // Verdict is issued on the dv-fall edge so the last byte leaves one cycle after dv drops.
            state <= RX_EOF;
            if (count >= 14'd5) begin
              m_rx_axis_tvalid <= 1'b1;
              m_rx_axis_tlast  <= 1'b1;
              m_rx_axis_tdata  <= dl[4];
              m_rx_axis_tuser  <= crc_bad | er_seen | bad_len;
              stat_crc_err     <= crc_bad;
            end
          end else if (rgmii_mac_rx_rdy) begin
            if (rgmii_mac_rx_er) er_seen <= 1'b1;
            if (byte_stb) begin
              dl[0] <= rx_byte;
              for (int unsigned i = 1; i < 5; i++) dl[i] <= dl[i-1];
              crc <= crc32_byte(crc, rx_byte);
              if (count != '1) count <= count + 14'd1;
              if (dl_cnt == 3'd5) begin
                m_rx_axis_tvalid <= 1'b1;
                m_rx_axis_tdata  <= dl[4];
              end else begin
                dl_cnt <= dl_cnt + 3'd1;
              end
            end
          end
        end
        RX_EOF: begin
          dl_cnt  <= '0;
          count   <= '0;
          crc     <= '1;
          er_seen <= 1'b0;
          pre_cnt <= '0;
          state   <= (rgmii_mac_rx_rdy && rgmii_mac_rx_dv) ? RX_PREAMBLE : RX_IDLE;
        end
        RX_DROP: begin
          if (rgmii_mac_rx_rdy && !rgmii_mac_rx_dv) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule
